// File: rtl/live_generator.sv
// live_generator: periodic beam-live (spill gate) generator with programmable
// ON/OFF lengths, a spill counter and an optional spill limit.
// Optional feature: define LIVE_GLITCH_EN to add the glitch_len input and the
// GLITCH_OFFSET parameter, which force out_live low inside every ON period.
module live_generator #(
    parameter logic [31:0] DEF_ON_PERIOD  = 32'd437500000,
    parameter logic [31:0] DEF_OFF_PERIOD = 32'd125000000,
    parameter int unsigned SPILL_W        = 16
`ifdef LIVE_GLITCH_EN
    ,
    parameter int unsigned GLITCH_OFFSET  = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [31:0]        on_period,
    input  logic [31:0]        off_period,
    input  logic [SPILL_W-1:0] n_spills,
`ifdef LIVE_GLITCH_EN
    input  logic [7:0]         glitch_len,
`endif
    output logic               out_live,
    output logic               spill_start,
    output logic               spill_end,
    output logic [SPILL_W-1:0] spill_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] toff_q;
    logic [31:0] eff_on_c;
    logic [31:0] eff_off_c;
    logic        live_first_c;
    logic        live_next_c;
    logic        limit_hit_c;

    // Zero on a period input selects the build-time default.
    assign eff_on_c    = (on_period  == 32'd0) ? DEF_ON_PERIOD  : on_period;
    assign eff_off_c   = (off_period == 32'd0) ? DEF_OFF_PERIOD : off_period;
    assign limit_hit_c = (n_spills != '0) && (spill_cnt == n_spills);

`ifdef LIVE_GLITCH_EN
    logic [31:0] on_pos;

    function automatic logic glitch_hit(input logic [31:0] p);
        return (glitch_len != 8'd0) &&
               (p >= 32'(GLITCH_OFFSET)) &&
               ((p - 32'(GLITCH_OFFSET)) < 32'(glitch_len));
    endfunction

    // Position of the current cycle inside the ON period, 0 on the rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_pos <= 32'd0;
        end else if ((state == S_ON) && (cnt != 32'd0)) begin
            on_pos <= on_pos + 32'd1;
        end else begin
            on_pos <= 32'd0;
        end
    end

    assign live_first_c = ~glitch_hit(32'd0);
    assign live_next_c  = ~glitch_hit(on_pos + 32'd1);
`else
    assign live_first_c = 1'b1;
    assign live_next_c  = 1'b1;
`endif

    // Main FSM: period down-counters, spill accounting and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 32'd0;
            toff_q      <= 32'd0;
            out_live    <= 1'b0;
            spill_start <= 1'b0;
            spill_end   <= 1'b0;
            spill_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            spill_start <= 1'b0;
            spill_end   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state       <= S_ON;
                        cnt         <= eff_on_c - 32'd1;
                        toff_q      <= eff_off_c;
                        out_live    <= live_first_c;
                        spill_start <= 1'b1;
                        spill_cnt   <= SPILL_W'(1);
                        busy        <= 1'b1;
                    end
                end
                S_ON: begin
                    if (cnt == 32'd0) begin
                        state     <= S_OFF;
                        cnt       <= toff_q - 32'd1;
                        out_live  <= 1'b0;
                        spill_end <= 1'b1;
                    end else begin
                        cnt      <= cnt - 32'd1;
                        out_live <= live_next_c;
                    end
                end
                S_OFF: begin
                    if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else if (limit_hit_c) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= S_ON;
                        cnt         <= eff_on_c - 32'd1;
                        toff_q      <= eff_off_c;
                        out_live    <= live_first_c;
                        spill_start <= 1'b1;
                        spill_cnt   <= spill_cnt + SPILL_W'(1);
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    out_live <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_live_generator.sv
// Self-checking bench for live_generator: table-driven runs, hand-written
// corner sequences and randomized stimulus against a spill-level model.
module tb_live_generator;

    localparam int unsigned SPILL_W = 16;
    localparam int          DEF_ON  = 6;
    localparam int          DEF_OFF = 2;
    localparam int          GOFF    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [31:0]        on_period;
    logic [31:0]        off_period;
    logic [SPILL_W-1:0] n_spills;
    logic [7:0]         glitch_len;
    logic               out_live;
    logic               spill_start;
    logic               spill_end;
    logic [SPILL_W-1:0] spill_cnt;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    live_generator #(
        .DEF_ON_PERIOD (32'd6),
        .DEF_OFF_PERIOD(32'd2),
        .SPILL_W       (SPILL_W)
`ifdef LIVE_GLITCH_EN
        ,
        .GLITCH_OFFSET (GOFF)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .on_period  (on_period),
        .off_period (off_period),
        .n_spills   (n_spills),
`ifdef LIVE_GLITCH_EN
        .glitch_len (glitch_len),
`endif
        .out_live   (out_live),
        .spill_start(spill_start),
        .spill_end  (spill_end),
        .spill_cnt  (spill_cnt),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic               live;
        logic               start;
        logic               endp;
        logic [SPILL_W-1:0] cnt;
        logic               busy;
        logic               done;
    } exp_t;

    typedef struct {
        int on;
        int off;
        int nsp;
        int per;
        int highs;
        int done_at;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a queue holding one expected record per cycle of the
    // spill in flight, plus the run mode (0 idle, 1 running, 2 done).
    exp_t               q[$];
    int                 mode  = 0;
    logic [SPILL_W-1:0] m_cnt = '0;
    exp_t               exp_now;

    function automatic exp_t dut_vec();
        return '{out_live, spill_start, spill_end, spill_cnt, busy, done};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic bit glitch_at(input int k);
`ifdef LIVE_GLITCH_EN
        return (glitch_len != 8'd0) && (k >= GOFF) && (k < GOFF + int'(glitch_len));
`else
        return (k < 0);
`endif
    endfunction

    task automatic model_start();
        int   ton;
        int   toff;
        exp_t e;
        ton  = (on_period  == 32'd0) ? DEF_ON  : int'(on_period);
        toff = (off_period == 32'd0) ? DEF_OFF : int'(off_period);
        m_cnt = m_cnt + 1'b1;
        for (int k = 0; k < ton + toff; k++) begin
            e.live  = (k < ton) && !glitch_at(k);
            e.start = (k == 0);
            e.endp  = (k == ton);
            e.cnt   = m_cnt;
            e.busy  = 1'b1;
            e.done  = 1'b0;
            q.push_back(e);
        end
        mode = 1;
    endtask

    task automatic model_edge();
        if (rst) begin
            q.delete();
            mode  = 0;
            m_cnt = '0;
            exp_now = '0;
            return;
        end
        if (q.size() == 0) begin
            case (mode)
                0: if (enable) begin
                    m_cnt = '0;
                    model_start();
                end
                1: begin
                    if ((n_spills != '0) && (m_cnt == n_spills)) mode = 2;
                    else if (!enable) mode = 0;
                    else model_start();
                end
                default: if (!enable) mode = 0;
            endcase
        end
        if (q.size() > 0) exp_now = q.pop_front();
        else exp_now = '{1'b0, 1'b0, 1'b0, m_cnt, 1'b0, mode == 2};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("cycle_outputs", 64'(dut_vec()), 64'(exp_now));
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        #1;
        check("reset_outputs", 64'(dut_vec()), 64'd0);
        q.delete();
        mode  = 0;
        m_cnt = '0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    vec_t tbl[5];
    int   highs;
    int   starts;
    int   first_done;
    int   start_at[8];
    int   hi1;
    int   hi2;
    logic [9:0] pat;

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        on_period  = 32'd0;
        off_period = 32'd0;
        n_spills   = '0;
        glitch_len = 8'd0;

        tbl[0] = '{10, 4, 3, 14, 30, 43};
        tbl[1] = '{0,  0, 2,  8, 12, 17};
        tbl[2] = '{1,  1, 4,  2,  4,  9};
        tbl[3] = '{3,  0, 2,  5,  6, 11};
        tbl[4] = '{0,  5, 1, 11,  6, 12};

        // Table: limited runs with enable held high.
        for (int i = 0; i < 5; i++) begin
            apply_rst();
            on_period  = 32'(tbl[i].on);
            off_period = 32'(tbl[i].off);
            n_spills   = SPILL_W'(tbl[i].nsp);
            enable     = 1'b1;
            highs = 0; starts = 0; first_done = 0;
            for (int k = 0; k < 60; k++) begin
                step();
                if (out_live) highs++;
                if (spill_start) begin
                    if (starts < 8) start_at[starts] = cyc;
                    starts++;
                end
                if (done && first_done == 0) first_done = cyc;
            end
            check("tbl_highs", 64'(highs), 64'(tbl[i].highs));
            check("tbl_starts", 64'(starts), 64'(tbl[i].nsp));
            check("tbl_done_at", 64'(first_done), 64'(tbl[i].done_at));
            check("tbl_cnt", 64'(spill_cnt), 64'(tbl[i].nsp));
            for (int j = 0; j < tbl[i].nsp; j++)
                check("tbl_start_at", 64'(start_at[j]), 64'(1 + j * tbl[i].per));
            enable = 1'b0;
            step();
            step();
            check("tbl_idle_after_done", 64'({busy, done, out_live}), 64'd0);
        end

        // Enable dropped two cycles into the 4th ON period.
        apply_rst();
        on_period = 32'd5; off_period = 32'd3; n_spills = '0; enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cyc == 26) enable = 1'b0;
        end
        check("drop_cnt", 64'(spill_cnt), 64'd4);
        check("drop_busy_done", 64'({busy, done}), 64'd0);
        enable = 1'b1;
        step();
        check("restart_cnt", 64'({spill_start, spill_cnt}), 64'({1'b1, 16'd1}));

        // on_period changed mid-ON affects only the next spill.
        apply_rst();
        on_period = 32'd10; off_period = 32'd4; n_spills = '0; enable = 1'b1;
        hi1 = 0; hi2 = 0;
        for (int k = 0; k < 38; k++) begin
            step();
            if (cyc == 3) on_period = 32'd20;
            if (out_live) begin
                if (cyc <= 14) hi1++;
                else hi2++;
            end
        end
        check("chg_first_len", 64'(hi1), 64'd10);
        check("chg_second_len", 64'(hi2), 64'd20);
        enable = 1'b0;
        for (int k = 0; k < 30; k++) step();

        // Reset three cycles into ON, then resume with enable still high.
        apply_rst();
        on_period = 32'd8; off_period = 32'd3; n_spills = '0; enable = 1'b1;
        step(); step(); step();
        apply_rst();
        step();
        check("resume_start", 64'({out_live, spill_start, spill_cnt}), 64'({1'b1, 1'b1, 16'd1}));
        for (int k = 0; k < 20; k++) step();

`ifdef LIVE_GLITCH_EN
        // Glitch shape, plain and clipped at the end of ON.
        for (int g = 0; g < 2; g++) begin
            apply_rst();
            glitch_len = (g == 0) ? 8'd2 : 8'd8;
            on_period = 32'd10; off_period = 32'd4; n_spills = SPILL_W'(1); enable = 1'b1;
            pat = '0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (cyc >= 1 && cyc <= 10) pat = {pat[8:0], out_live};
            end
            check("glitch_pattern", 64'(pat), (g == 0) ? 64'h3CF : 64'h3C0);
            enable = 1'b0;
            step();
        end
        glitch_len = 8'd3;
`endif

        // Randomized stimulus against the model.
        apply_rst();
        enable = 1'b1;
        on_period = 32'd3; off_period = 32'd2; n_spills = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39, 0) == 0) on_period  = 32'($urandom_range(6, 0));
            if ($urandom_range(39, 0) == 0) off_period = 32'($urandom_range(5, 0));
            if ($urandom_range(29, 0) == 0) enable     = ~enable;
            if ($urandom_range(99, 0) == 0) n_spills   = SPILL_W'($urandom_range(4, 0));
            if ($urandom_range(499, 0) == 0) apply_rst();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
